// File: rtl/cache_mem_pkg.sv
// Shared widths and FSM state encoding for the memory-side line responder.
package cache_mem_pkg;
    localparam int LINE_W     = 128;
    localparam int MEM_ADDR_W = 28;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port, one combinational read port, no reset.
module mem_line_array
    import cache_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [LINE_W-1:0]     rd_line
);
    logic [LINE_W-1:0] lines [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_idx] <= wr_line;
        end
    end

    assign rd_line = lines[rd_idx];
endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency 128-bit line responder facing the cache controller, with
// read/write completion counters and a sticky protocol-error flag.
module mem_line_responder
    import cache_mem_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    output logic [CNT_W-1:0]      read_count,
    output logic [CNT_W-1:0]      write_count,
    output logic                  proto_err
);
    state_t                state;
    logic [7:0]            count;
    logic                  op_write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [LINE_W-1:0]     wdata_q;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [LINE_W-1:0]     rd_line;
    logic                  wr_en;
    logic                  accept;
    logic                  unused_addr;

    // Upper address bits alias onto the stored lines.
    assign req_idx     = mem_addr[DEPTH_LOG2-1:0];
    assign unused_addr = ^(mem_addr >> DEPTH_LOG2);

    assign accept = (state == S_IDLE) && (mem_read ^ mem_write);
    // With LATENCY=1 the line is fetched in the accepting cycle, before idx is latched.
    assign rd_idx = (state == S_IDLE) ? req_idx : idx;
    assign wr_en  = (state == S_RESP) && op_write && !proc_reset;

    mem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (idx),
        .wr_line(wdata_q),
        .rd_idx (rd_idx),
        .rd_line(rd_line)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state       <= S_IDLE;
            count       <= '0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            read_count  <= '0;
            write_count <= '0;
            proto_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_read && mem_write) begin
                        proto_err <= 1'b1;
                    end else if (accept) begin
                        op_write <= mem_write;
                        idx      <= req_idx;
                        wdata_q  <= mem_wdata;
                        if (LATENCY == 1) begin
                            state     <= S_RESP;
                            mem_ready <= 1'b1;
                            mem_rdata <= mem_write ? '0 : rd_line;
                        end else begin
                            state <= S_BUSY;
                            count <= 8'(LATENCY - 1);
                        end
                    end
                end
                S_BUSY: begin
                    if (count == 8'd1) begin
                        state     <= S_RESP;
                        count     <= '0;
                        mem_ready <= 1'b1;
                        mem_rdata <= op_write ? '0 : rd_line;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                S_RESP: begin
                    // Request is still held here; returning to IDLE avoids re-accepting it.
                    state     <= S_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                    if (op_write) begin
                        write_count <= write_count + 1'b1;
                    end else begin
                        read_count <= read_count + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
